// File: rtl/opcode_lookup_arbiter.sv
// rtl/opcode_lookup_arbiter.sv - round-robin arbiter sequencing a shared name-to-opcode lookup datapath
// One owner at a time streams its null-terminated name, then waits for Ready or a timeout.
module opcode_lookup_arbiter #(
    parameter int NREQ   = 2,
    parameter int MAXLEN = 16,
    parameter int TMO    = 16383
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_char,
    output logic [NREQ-1:0]   o_char_ack,
    output logic [NREQ-1:0]   o_done,
    output logic              o_err,
    output logic [7:0]        o_opcode_out,
    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic [7:0]        o_name,
    output logic              o_start,
    input  logic [7:0]        i_opcode,
    input  logic              i_ready
);

    localparam int LW = $clog2(MAXLEN + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]      r_state;
    logic [1:0]      r_grant;
    logic [1:0]      r_ptr;
    logic [LW-1:0]   r_len;
    logic [13:0]     r_tmo;
    logic            r_err;
    logic [7:0]      r_opcode;

    logic [1:0]      w_pick;
    logic [7:0]      w_char;
    logic [NREQ-1:0] w_grant_oh;
    logic [LW-1:0]   w_len_nxt;
    logic [13:0]     w_tmo_nxt;

    // Scan from the farthest candidate down so the nearest one after r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (int'(r_ptr) + k) % NREQ && i_req[i]) begin
                    w_pick = 2'(i);
                end
            end
        end
    end

    always_comb begin
        w_char = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == 2'(i)) begin
                w_char = i_char[8*i +: 8];
            end
        end
    end

    assign w_grant_oh = NREQ'(1) << r_grant;
    assign w_len_nxt  = r_len + LW'(1);
    assign w_tmo_nxt  = r_tmo + 14'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= 2'd0;
            r_ptr    <= 2'(NREQ - 1);
            r_len    <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_opcode <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_pick;
                        r_state <= S_START;
                    end
                end
                S_START: r_state <= S_GAP;
                S_GAP: begin
                    r_len   <= '0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_len <= w_len_nxt;
                    if (w_char == 8'h00) begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else if (w_len_nxt == LW'(MAXLEN)) begin
                        // Over-length: WAIT drives the terminator the datapath never got.
                        r_err   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_tmo <= w_tmo_nxt;
                    if (i_ready) begin
                        r_opcode <= i_opcode;
                        r_state  <= S_DONE;
                    end else if (w_tmo_nxt == 14'(TMO)) begin
                        r_opcode <= 8'hFF;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_start      = (r_state == S_START);
    assign o_name       = (r_state == S_SEND) ? w_char : 8'h00;
    assign o_char_ack   = (r_state == S_SEND) ? w_grant_oh : '0;
    assign o_done       = (r_state == S_DONE) ? w_grant_oh : '0;
    assign o_err        = (r_state == S_DONE) && r_err;
    assign o_opcode_out = r_opcode;
    assign o_grant      = r_grant;

endmodule

// File: doc/opcode_lookup_arbiter.md
Name: opcode_lookup_arbiter

Overview:
- Shares one opcode-conversion datapath (name-string in, 8-bit opcode out) between NREQ requesters, e.g. the assembler front-end and the debug/monitor port.
- Grants round-robin and sequences the datapath's Start/Name/Ready protocol.
- Streams the granted requester's null-terminated name one character per cycle.
- Returns the opcode, or an error on timeout or over-length name.

Parameters:
- NREQ, 2, number of requesters (2..4); PW = 2 bits of grant index.
- MAXLEN, 16, max characters per name excluding the terminator.
- TMO, 16383, max cycles waiting for Ready after the terminator; the timeout counter is 14 bits.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Req  input  NREQ  per-requester lookup request, level, held until its Done.
- Char  input  8*NREQ  per-requester current name character, slice i = Char[8i+7:8i]; 0x00 = terminator.
- CharAck  output  NREQ  one-cycle pop strobe to the granted requester's character source.
- Done  output  NREQ  one-cycle completion pulse to the granted requester.
- Err  output  1  valid with any Done; 1 = timeout or over-length.
- OpcodeOut  output  8  result, valid with Done, held until the next Done.
- Grant  output  PW  index of the current or last owner.
- Busy  output  1  high in every state except IDLE.
- Name  output  8  character to the datapath.
- Start  output  1  one-cycle start pulse to the datapath.
- Opcode  input  8  datapath result.
- Ready  input  1  datapath result valid, level.

Behaviour:
- Reset (Rst=0, any state):
  - Enters IDLE immediately.
  - All outputs 0; round-robin pointer = NREQ-1 (requester 0 wins first); counters 0.
  - Mid-operation reset is legal; the datapath is re-synchronised by its own reset.
- FSM states: IDLE, START, GAP, SEND, WAIT, DONE.
- IDLE:
  - If any Req, pick the first requester set, searching upward from pointer+1 modulo NREQ.
  - Latch Grant, update pointer = Grant, go to START.
- START: Start=1 for exactly this cycle; Name=0x00; go to GAP.
- GAP:
  - One idle cycle, Name=0x00; the datapath requires one cycle between Start and the first character.
  - Clear the length counter; go to SEND.
- SEND, each cycle:
  - Name = Char[Grant].
  - CharAck[Grant]=1, so the requester presents the next character on the following cycle.
  - Length counter +1.
  - If Char[Grant]==0x00: go to WAIT, clear the timeout counter.
  - Else if the counter reaches MAXLEN with no terminator: next cycle drive Name=0x00 (no CharAck), set the err flag, go to WAIT.
  - A name of length L therefore gives L+1 CharAck pulses; an empty name gives 1 CharAck then WAIT.
- WAIT:
  - Name=0x00; the timeout counter increments every cycle.
  - If Ready=1: latch OpcodeOut=Opcode, go to DONE.
  - Ready takes priority over timeout on the same cycle.
  - If the counter reaches TMO: OpcodeOut=0xFF, err flag=1, go to DONE.
- DONE:
  - Done[Grant]=1 and Err=err flag for one cycle.
  - Clear the err flag; go to IDLE.
  - Next arbitration occurs in IDLE, so there is one idle cycle minimum between grants.
- Req dropped by the owner before Done is ignored; the transaction completes and Done still pulses.
- Req of a non-owner is never acknowledged until granted.
- Only Grant's CharAck/Done bits may ever be 1; all others remain 0.
- Name changes only on the rising edge, so it is stable for the datapath sample.
- Latency: Start to first character = 2 cycles. End-to-end = 2 + (L+1) + Ready delay + 1 (DONE) cycles, plus one IDLE cycle before the next grant.

Test Plan:
- Reset mid-SEND (Rst=0 for 1 cycle) -> all outputs 0 asynchronously; Busy=0; Req0 then wins in IDLE.
- Req0 only, name "num" (0x6E,0x75,0x6D,0x00), model Ready 5 cycles after the terminator with Opcode=0x12:
  - Start pulse; Name sequence 6E,75,6D,00 starting 2 cycles after Start; 4 CharAck[0] pulses.
  - Done[0]=1 with OpcodeOut=0x12, Err=0.
- Req0 and Req1 both held continuously, two lookups each -> grants alternate 0,1,0,1; Done pulses only on the granted index.
- 20-character name without terminator:
  - Exactly 16 CharAck pulses, then Name=0x00.
  - After Ready returns, Done with Err=1.
- Ready never asserted, TMO reduced to 8 -> Done 8 cycles after entering WAIT; OpcodeOut=0xFF, Err=1.
- Ready arriving on the same cycle the timeout expires -> OpcodeOut=Opcode, Err=0.
